digit_scan: RTL and testbench
=============================

Name: digit_scan

Overview:
- Time-multiplexed scanner for a multi-digit seven-segment display.
- Holds a NUM_DIGITS-nibble display value and presents one nibble per time slot on nibble_out.
- nibble_out feeds the shared active-low hex-to-seven-segment decoder, and digit_sel drives the common digit enables.
- Supports tear-free value update at frame boundaries, per-digit blanking and leading-zero suppression.

Parameters:
- NUM_DIGITS, 4, number of display digits scanned (2..8).
- REFRESH_DIV, 50000, clock cycles each digit slot is held (>=1).

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- reset  input  1  synchronous, active-high reset.
- value  input  4*NUM_DIGITS  display value; nibble i (bits 4i+3:4i) is digit i, digit 0 rightmost.
- load  input  1  one-cycle strobe; captures value for display from the next frame.
- blank_mask  input  NUM_DIGITS  bit i=1 forces digit i dark; sampled live.
- lz_suppress  input  1  1 = blank leading zero digits; sampled live.
- nibble_out  output  4  nibble of the active digit, to the decoder.
- digit_sel  output  NUM_DIGITS  active-low one-hot digit enable; all ones = display dark.
- digit_blank  output  1  1 when the current slot is dark.
- slot_tick  output  1  one-cycle pulse after each slot change.

Behaviour:
- State: prescaler 0..REFRESH_DIV-1, index 0..NUM_DIGITS-1, hold register (4*NUM_DIGITS), pending flag, shadow register (4*NUM_DIGITS).
- Reset values: prescaler=0, index=NUM_DIGITS-1, hold=0, shadow=0, pending=0, nibble_out=0, digit_sel=all ones, digit_blank=1, slot_tick=0.
- Reset is synchronous and has priority over every other event, including mid-frame. Outputs take reset values on the edge where reset is sampled high.
- Prescaler increments every cycle. When prescaler==REFRESH_DIV-1 (the "advance edge"):
  - prescaler<=0.
  - index<=index+1, wrapping NUM_DIGITS-1 -> 0.
  - The advance edge with the new index equal to 0 is the frame boundary.
- REFRESH_DIV=1: every edge is an advance edge.
- load: hold<=value and pending<=1 on that edge.
- Frame boundary with pending=1: shadow<=hold, pending<=0.
- load on a frame-boundary edge: the bypass applies, so shadow<=value directly and pending stays 0. The new value is visible in slot 0 of this frame.
- load mid-frame: the current frame completes with the old shadow.
- Outputs are registered and updated only on advance edges, computed from the new index k, the shadow value after this edge, and the live blank_mask/lz_suppress:
  - dark = blank_mask[k] OR (lz_suppress AND k!=0 AND shadow nibbles k..NUM_DIGITS-1 all zero).
  - Digit 0 is never zero-suppressed; value 0 shows a single "0".
  - nibble_out = shadow nibble k (driven even when dark).
  - digit_blank = dark.
  - digit_sel = all ones if dark, else all ones with bit k cleared.
- Between advance edges, outputs hold. Changes to blank_mask/lz_suppress take effect at the next slot.
- slot_tick is 1 exactly one cycle after each advance edge, otherwise 0.
- First advance edge after reset release: the REFRESH_DIV-th cycle. It selects digit 0 and is a frame boundary.
- A load before that edge is displayed in the first frame.

Test Plan (NUM_DIGITS=4, REFRESH_DIV=4):
- Reset for 2 cycles, then release.
  - During reset: digit_sel=1111, digit_blank=1, nibble_out=0, slot_tick=0.
  - On the 4th post-release edge, digit_sel goes to 1110 with nibble 0, and slot_tick pulses on the next cycle.
- load value=16'h1A3F right after reset.
  - Slots show (nibble_out, digit_sel) = (F,1110), (3,1101), (A,1011), (1,0111), each held exactly 4 cycles, then wrap to (F,1110).
- Steady 16'h1A3F, then load 16'h2222 while index=1.
  - Digits 2 and 3 still show A and 1.
  - Next slot 0 shows 2; all digits show 2 thereafter.
- lz_suppress=1, value 16'h0050.
  - Digits 3 and 2 dark (digit_sel=1111, digit_blank=1); digit 1 shows 5; digit 0 shows 0.
  - With value 16'h0000, only digit 0 lit, showing 0.
- blank_mask=4'b0100, value 16'h1234.
  - Digit 2 slot dark; other slots show 4, 3, 1.
  - Clearing the mask mid-slot 2 keeps it dark until the next slot.
- Load coincident with the frame-boundary edge shows the new digit 0 in that same slot.
- Reset asserted during index=2 clears shadow; after release the display shows 0s.

Source files
------------

// File: rtl/digit_scan.sv
// Time-multiplexed seven-segment digit scanner: one nibble per slot, tear-free
// frame-boundary value update, per-digit blanking and leading-zero suppression.
module digit_scan #(
  parameter int NUM_DIGITS  = 4,
  parameter int REFRESH_DIV = 50000
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [4*NUM_DIGITS-1:0] value,
  input  logic                    load,
  input  logic [NUM_DIGITS-1:0]   blank_mask,
  input  logic                    lz_suppress,
  output logic [3:0]              nibble_out,
  output logic [NUM_DIGITS-1:0]   digit_sel,
  output logic                    digit_blank,
  output logic                    slot_tick
);

  localparam int IW = $clog2(NUM_DIGITS);
  localparam int PW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam logic [IW-1:0] LAST = IW'(NUM_DIGITS - 1);
  localparam logic [PW-1:0] PMAX = PW'(REFRESH_DIV - 1);

  logic [PW-1:0]                presc;
  logic [IW-1:0]                idx, idx_nxt;
  logic [NUM_DIGITS-1:0][3:0]   hold, shadow, shadow_nxt;
  logic                         pending;
  logic                         adv, frame, dark;
  logic [NUM_DIGITS-1:0]        upper_zero;

  always_comb begin
    adv        = (presc == PMAX);
    frame      = adv && (idx == LAST);
    idx_nxt    = idx;
    if (adv) idx_nxt = (idx == LAST) ? '0 : idx + 1'b1;
    // A load landing on the boundary edge bypasses hold so slot 0 shows it now.
    shadow_nxt = shadow;
    if (frame && load)         shadow_nxt = value;
    else if (frame && pending) shadow_nxt = hold;
  end

  // upper_zero[g]: digits g..top of the next shadow are all zero.
  for (genvar g = 0; g < NUM_DIGITS; g++) begin : g_uz
    assign upper_zero[g] = (shadow_nxt[NUM_DIGITS-1:g] == '0);
  end

  always_comb begin
    dark = blank_mask[idx_nxt] | (lz_suppress & (idx_nxt != '0) & upper_zero[idx_nxt]);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      presc       <= '0;
      idx         <= LAST;
      hold        <= '0;
      shadow      <= '0;
      pending     <= 1'b0;
      nibble_out  <= 4'h0;
      digit_sel   <= '1;
      digit_blank <= 1'b1;
      slot_tick   <= 1'b0;
    end else begin
      presc     <= adv ? '0 : presc + 1'b1;
      idx       <= idx_nxt;
      shadow    <= shadow_nxt;
      slot_tick <= adv;
      if (load) hold <= value;
      if (frame)     pending <= 1'b0;
      else if (load) pending <= 1'b1;
      if (adv) begin
        nibble_out  <= shadow_nxt[idx_nxt];
        digit_blank <= dark;
        digit_sel   <= dark ? '1 : ~(NUM_DIGITS'(1) << idx_nxt);
      end
    end
  end

endmodule

// File: tb/tb_digit_scan.sv
// Directed bench for digit_scan (4 digits, 4-cycle slots) with hand-computed
// slot sequences covering reset, frame-synchronous load, blanking and LZ suppression.
module tb_digit_scan;

  logic        clk = 1'b0;
  logic        reset;
  logic [15:0] value;
  logic        load;
  logic [3:0]  blank_mask;
  logic        lz_suppress;
  logic [3:0]  nibble_out;
  logic [3:0]  digit_sel;
  logic        digit_blank;
  logic        slot_tick;

  int n_tests = 0;
  int n_fail  = 0;

  digit_scan #(.NUM_DIGITS(4), .REFRESH_DIV(4)) dut (
    .clk(clk), .reset(reset), .value(value), .load(load),
    .blank_mask(blank_mask), .lz_suppress(lz_suppress),
    .nibble_out(nibble_out), .digit_sel(digit_sel),
    .digit_blank(digit_blank), .slot_tick(slot_tick)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h @%0t", tag, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic chk_out(input string tag, input logic [3:0] nib, input logic [3:0] sel,
                         input logic blk);
    check({tag, ".nib"}, 32'(nibble_out), 32'(nib));
    check({tag, ".sel"}, 32'(digit_sel), 32'(sel));
    check({tag, ".blk"}, 32'(digit_blank), 32'(blk));
  endtask

  // Entered just after an advance edge; leaves just after the next one.
  // load is dropped after the first edge so a caller can pulse it for one cycle.
  task automatic run_slot(input string tag, input logic [3:0] nib, input logic [3:0] sel,
                          input logic blk);
    chk_out(tag, nib, sel, blk);
    check({tag, ".tick1"}, 32'(slot_tick), 32'd1);
    for (int i = 0; i < 3; i++) begin
      tick(); load = 1'b0;
      chk_out(tag, nib, sel, blk);
      check({tag, ".tick0"}, 32'(slot_tick), 32'd0);
    end
    tick(); load = 1'b0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick(); tick();
    chk_out("rst", 4'h0, 4'b1111, 1'b1);
    check("rst.tick", 32'(slot_tick), 32'd0);
  endtask

  initial begin
    reset = 1'b1; value = '0; load = 1'b0; blank_mask = '0; lz_suppress = 1'b0;

    // Reset and first advance on the 4th post-release edge.
    do_reset();
    reset = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk_out("pre_adv", 4'h0, 4'b1111, 1'b1);
    end
    tick();
    run_slot("first", 4'h0, 4'b1110, 1'b0);

    // Load right after release shows in the first frame.
    do_reset();
    reset = 1'b0; load = 1'b1; value = 16'h1A3F;
    tick(); load = 1'b0;
    tick(); tick();
    check("ld0.sel", 32'(digit_sel), 32'hF);
    tick();
    run_slot("f1.d0", 4'hF, 4'b1110, 1'b0);
    run_slot("f1.d1", 4'h3, 4'b1101, 1'b0);
    run_slot("f1.d2", 4'hA, 4'b1011, 1'b0);
    run_slot("f1.d3", 4'h1, 4'b0111, 1'b0);
    run_slot("f2.d0", 4'hF, 4'b1110, 1'b0);

    // Mid-frame load (index 1) waits for the frame boundary.
    load = 1'b1; value = 16'h2222;
    run_slot("mid.d1", 4'h3, 4'b1101, 1'b0);
    run_slot("mid.d2", 4'hA, 4'b1011, 1'b0);
    run_slot("mid.d3", 4'h1, 4'b0111, 1'b0);
    run_slot("new.d0", 4'h2, 4'b1110, 1'b0);
    run_slot("new.d1", 4'h2, 4'b1101, 1'b0);
    run_slot("new.d2", 4'h2, 4'b1011, 1'b0);
    run_slot("new.d3", 4'h2, 4'b0111, 1'b0);

    // Leading-zero suppression.
    load = 1'b1; value = 16'h0050; lz_suppress = 1'b1;
    run_slot("lzp.d0", 4'h2, 4'b1110, 1'b0);
    run_slot("lzp.d1", 4'h2, 4'b1101, 1'b0);
    run_slot("lzp.d2", 4'h2, 4'b1011, 1'b0);
    run_slot("lzp.d3", 4'h2, 4'b0111, 1'b0);
    load = 1'b1; value = 16'h0000;
    run_slot("lz50.d0", 4'h0, 4'b1110, 1'b0);
    run_slot("lz50.d1", 4'h5, 4'b1101, 1'b0);
    run_slot("lz50.d2", 4'h0, 4'b1111, 1'b1);
    run_slot("lz50.d3", 4'h0, 4'b1111, 1'b1);
    run_slot("lz00.d0", 4'h0, 4'b1110, 1'b0);
    run_slot("lz00.d1", 4'h0, 4'b1111, 1'b1);
    run_slot("lz00.d2", 4'h0, 4'b1111, 1'b1);
    run_slot("lz00.d3", 4'h0, 4'b1111, 1'b1);

    // Per-digit blanking, live mask update takes effect at the next slot.
    load = 1'b1; value = 16'h1234; lz_suppress = 1'b0; blank_mask = 4'b0100;
    run_slot("bmp.d0", 4'h0, 4'b1110, 1'b0);
    run_slot("bmp.d1", 4'h0, 4'b1101, 1'b0);
    run_slot("bmp.d2", 4'h0, 4'b1111, 1'b1);
    run_slot("bmp.d3", 4'h0, 4'b0111, 1'b0);
    run_slot("bm.d0", 4'h4, 4'b1110, 1'b0);
    run_slot("bm.d1", 4'h3, 4'b1101, 1'b0);
    chk_out("bm.d2", 4'h2, 4'b1111, 1'b1);
    tick(); blank_mask = 4'b0000;
    tick();
    chk_out("bm.d2hold", 4'h2, 4'b1111, 1'b1);
    tick(); tick();
    run_slot("bm.d3", 4'h1, 4'b0111, 1'b0);
    run_slot("bmc.d0", 4'h4, 4'b1110, 1'b0);
    run_slot("bmc.d1", 4'h3, 4'b1101, 1'b0);
    run_slot("bmc.d2", 4'h2, 4'b1011, 1'b0);

    // Load coincident with the frame-boundary edge: bypass to slot 0.
    chk_out("byp.d3", 4'h1, 4'b0111, 1'b0);
    tick(); tick(); tick();
    load = 1'b1; value = 16'h9876;
    tick(); load = 1'b0;
    run_slot("byp.d0", 4'h6, 4'b1110, 1'b0);
    run_slot("byp.d1", 4'h7, 4'b1101, 1'b0);

    // Reset during index 2 clears the shadow.
    chk_out("prerst.d2", 4'h8, 4'b1011, 1'b0);
    tick();
    do_reset();
    reset = 1'b0;
    tick(); tick(); tick();
    check("rr.sel", 32'(digit_sel), 32'hF);
    tick();
    run_slot("rr.d0", 4'h0, 4'b1110, 1'b0);
    run_slot("rr.d1", 4'h0, 4'b1101, 1'b0);
    run_slot("rr.d2", 4'h0, 4'b1011, 1'b0);
    run_slot("rr.d3", 4'h0, 4'b0111, 1'b0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
